// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Fetch FSM encoding, widths and reset defaults.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/adder.sv
// Plain W-bit modular adder.
// Carry out is dropped so sums wrap at 2^W.
module adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ack, skid buffer, IF/ID register.
// Redirects flush younger work; an in-flight fetch is drained and dropped.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_instr_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               ifid_valid_o,
  output logic [ADDR_W-1:0]  ifid_pc_o,
  output logic [ADDR_W-1:0]  ifid_pc4_o,
  output logic [INSTR_W-1:0] ifid_instr_o
);

  fetch_state_e state_q, state_d;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  drain_q, drain_d;
  logic [ADDR_W-1:0]  pc4;
  logic [ADDR_W-1:0]  target;

  logic               ifid_valid_d;
  logic [ADDR_W-1:0]  ifid_pc_d;
  logic [ADDR_W-1:0]  ifid_pc4_d;
  logic [INSTR_W-1:0] ifid_instr_d;

  logic               skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
  logic [ADDR_W-1:0]  skid_pc4_q, skid_pc4_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

  logic consume;
  logic space;
  logic unused_redirect_lsb;

  adder #(.W(ADDR_W)) u_pc_inc (
    .a   (pc_q),
    .b   (ADDR_W'(4)),
    .sum (pc4)
  );

  assign target = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  assign consume = ifid_valid_o && !stall_i;
  assign space   = !ifid_valid_o || !stall_i;

  assign imem_req_o  = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr_o = (state_q == DRAIN) ? drain_q : pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_d      = drain_q;
    ifid_valid_d = ifid_valid_o;
    ifid_pc_d    = ifid_pc_o;
    ifid_pc4_d   = ifid_pc4_o;
    ifid_instr_d = ifid_instr_o;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_pc4_d   = skid_pc4_q;
    skid_instr_d = skid_instr_q;

    if (redirect_i) begin
      ifid_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect_i) pc_d = target;
      end
      FETCH: begin
        if (redirect_i) begin
          pc_d = target;
          if (!imem_ack_i) begin
            drain_d = pc_q;
            state_d = DRAIN;
          end
        end else if (imem_ack_i) begin
          pc_d = pc4;
          if (space) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc4;
            ifid_instr_d = imem_instr_i;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_q;
            skid_pc4_d   = pc4;
            skid_instr_d = imem_instr_i;
            state_d      = HOLD;
          end
        end else if (consume) begin
          ifid_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall_i) begin
          ifid_valid_d = skid_valid_q;
          ifid_pc_d    = skid_pc_q;
          ifid_pc4_d   = skid_pc4_q;
          ifid_instr_d = skid_instr_q;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      DRAIN: begin
        // pc already holds the redirect target; only the old ack matters
        if (redirect_i) pc_d = target;
        if (imem_ack_i) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drain_q      <= '0;
      ifid_valid_o <= 1'b0;
      ifid_pc_o    <= '0;
      ifid_pc4_o   <= '0;
      ifid_instr_o <= NOP_INSTR;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_pc4_q   <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_q      <= drain_d;
      ifid_valid_o <= ifid_valid_d;
      ifid_pc_o    <= ifid_pc_d;
      ifid_pc4_o   <= ifid_pc4_d;
      ifid_instr_o <= ifid_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: wait-state memory model plus
// a scoreboard of instructions decode should receive.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_instr_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic [31:0] ifid_instr_o;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_instr_i  (imem_instr_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ifid_valid_o  (ifid_valid_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_pc4_o    (ifid_pc4_o),
    .ifid_instr_o  (ifid_instr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          mem_wait = 0;
  int          wcnt = 0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] stale_addr = 32'h0;
  bit          stale = 1'b0;
  bit          req_prev = 1'b0;
  bit          ack_prev = 1'b0;
  logic [31:0] addr_prev = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic clear_model();
    sb.delete();
    exp_addr  = 32'h0;
    stale     = 1'b0;
    wcnt      = 0;
    req_prev  = 1'b0;
    ack_prev  = 1'b0;
    addr_prev = 32'h0;
  endtask

  // one clock: memory response, consume check, ack bookkeeping
  task automatic step();
    ent_t e;
    @(negedge clk);
    if (imem_req_o) begin
      if (req_prev && !ack_prev)
        chk("addr_stable", imem_addr_o, addr_prev);
      if (wcnt >= mem_wait) begin
        imem_ack_i   = 1'b1;
        imem_instr_i = mk(imem_addr_o);
        wcnt         = 0;
      end else begin
        imem_ack_i = 1'b0;
        wcnt++;
      end
    end else begin
      imem_ack_i = 1'b0;
      wcnt       = 0;
    end
    if (!redirect_i && ifid_valid_o && !stall_i) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ifid_pc", ifid_pc_o, e.pc);
        chk("ifid_pc4", ifid_pc4_o, e.pc4);
        chk("ifid_instr", ifid_instr_o, e.instr);
      end
    end
    if (imem_ack_i) begin
      if (stale) begin
        chk("drain_addr", imem_addr_o, stale_addr);
        stale = 1'b0;
      end else begin
        chk("fetch_addr", imem_addr_o, exp_addr);
        if (!redirect_i) begin
          e.pc    = exp_addr;
          e.pc4   = exp_addr + 32'd4;
          e.instr = mk(exp_addr);
          sb.push_back(e);
        end
        exp_addr = exp_addr + 32'd4;
      end
    end
    if (redirect_i) begin
      sb.delete();
      if (imem_req_o && !imem_ack_i) begin
        if (!stale) stale_addr = imem_addr_o;
        stale = 1'b1;
      end
      exp_addr = {redirect_pc_i[31:2], 2'b00};
    end
    req_prev  = imem_req_o;
    ack_prev  = imem_ack_i;
    addr_prev = imem_addr_o;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, 32'(imem_req_o), 32'h0);
    chk({tag, "_valid"}, 32'(ifid_valid_o), 32'h0);
    chk({tag, "_pc"}, ifid_pc_o, 32'h0);
    chk({tag, "_pc4"}, ifid_pc4_o, 32'h0);
    chk({tag, "_instr"}, ifid_instr_o, 32'h0);
  endtask

  task automatic do_reset();
    rst_i        = 1'b0;
    imem_ack_i   = 1'b0;
    stall_i      = 1'b0;
    redirect_i   = 1'b0;
    mem_wait     = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset("rst");
    rst_i = 1'b1;
    clear_model();
    chk("idle_req", 32'(imem_req_o), 32'h0);
  endtask

  logic [31:0] a;

  initial begin
    imem_instr_i  = 32'h0;
    redirect_pc_i = 32'h0;

    // back-to-back zero-wait fetch
    do_reset();
    step();
    chk("t1_req", 32'(imem_req_o), 32'h1);
    chk("t1_addr0", imem_addr_o, 32'h0);
    step();
    chk("t1_pc_0", ifid_pc_o, 32'h0);
    chk("t1_pc4_4", ifid_pc4_o, 32'h4);
    chk("t1_addr4", imem_addr_o, 32'h4);
    step();
    chk("t1_pc_4", ifid_pc_o, 32'h4);
    chk("t1_addr8", imem_addr_o, 32'h8);
    step();
    chk("t1_pc_8", ifid_pc_o, 32'h8);
    chk("t1_pc4_12", ifid_pc4_o, 32'hc);
    chk("t1_addr12", imem_addr_o, 32'hc);

    // stall while the fetch at 8 acks
    do_reset();
    step();
    step();
    step();
    chk("t2_pc_4", ifid_pc_o, 32'h4);
    chk("t2_addr8", imem_addr_o, 32'h8);
    stall_i = 1'b1;
    step();
    chk("t2_hold_req", 32'(imem_req_o), 32'h0);
    chk("t2_hold_pc", ifid_pc_o, 32'h4);
    chk("t2_hold_valid", 32'(ifid_valid_o), 32'h1);
    step();
    step();
    chk("t2_still_pc", ifid_pc_o, 32'h4);
    stall_i = 1'b0;
    step();
    chk("t2_skid_pc", ifid_pc_o, 32'h8);
    chk("t2_resume_req", 32'(imem_req_o), 32'h1);
    chk("t2_resume_addr", imem_addr_o, 32'hc);
    step();
    step();

    // wrap at the top of the address space
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hffff_fffc;
    step();
    redirect_i = 1'b0;
    chk("wrap_addr", imem_addr_o, 32'hffff_fffc);
    step();
    chk("wrap_next", imem_addr_o, 32'h0);
    chk("wrap_pc", ifid_pc_o, 32'hffff_fffc);
    chk("wrap_pc4", ifid_pc4_o, 32'h0);

    // redirect beats stall, target LSBs dropped
    stall_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h103;
    step();
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    chk("flush_valid", 32'(ifid_valid_o), 32'h0);
    chk("flush_addr", imem_addr_o, 32'h100);
    step();
    chk("flush_pc", ifid_pc_o, 32'h100);

    // redirect during the first wait cycle of a slow fetch
    mem_wait      = 2;
    a             = exp_addr;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    step();
    redirect_i = 1'b0;
    chk("drain_req", 32'(imem_req_o), 32'h1);
    chk("drain_hold", imem_addr_o, a);
    step();
    chk("drain_valid", 32'(ifid_valid_o), 32'h0);
    step();
    chk("drain_tgt_req", 32'(imem_req_o), 32'h1);
    chk("drain_tgt_addr", imem_addr_o, 32'h40);
    chk("drain_dropped", 32'(ifid_valid_o), 32'h0);
    step();
    step();
    step();
    chk("drain_tgt_pc", ifid_pc_o, 32'h40);

    // mixed random traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) mem_wait = $urandom_range(0, 2);
      stall_i       = ($urandom_range(0, 3) == 0);
      redirect_i    = ($urandom_range(0, 15) == 0);
      redirect_pc_i = $urandom;
      step();
    end
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    mem_wait   = 0;
    for (int i = 0; i < 4; i++) step();

    // async reset while HOLD has the skid full
    stall_i = 1'b1;
    step();
    chk("pre_rst_req", 32'(imem_req_o), 32'h0);
    chk("pre_rst_valid", 32'(ifid_valid_o), 32'h1);
    #2;
    rst_i = 1'b0;
    #1;
    chk_reset("async");
    @(posedge clk);
    #1;
    rst_i   = 1'b1;
    stall_i = 1'b0;
    clear_model();
    chk("rel_idle_req", 32'(imem_req_o), 32'h0);
    step();
    chk("rel_req", 32'(imem_req_o), 32'h1);
    chk("rel_addr", imem_addr_o, 32'h0);
    step();
    chk("rel_pc", ifid_pc_o, 32'h0);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
